// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS boot/run control blocks.
//   boot_state_e : sequencer states
//   IMEM_ADDR_W  : width of the instruction-memory write address
//   IMEM_STEP    : default byte step between consecutive instruction words
package mips_ctrl_pkg;

    localparam int IMEM_ADDR_W = 32;
    localparam int IMEM_STEP   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RSTCPU,
        RUN,
        PASS,
        FAIL
    } boot_state_e;

endpackage

// File: rtl/imem_boot_sequencer_if.sv
// Bus bundle between the boot sequencer and its environment.
//   s_*     : program word stream (valid/ready, last marks the final word)
//   imem_*  : instruction-memory write port of the MIPS top
//   mem_*   : data-memory write bus of the MIPS top, watched for the pass signature
// Modports:
//   slave  : the boot sequencer side
//   master : the environment side (program source + MIPS top)
interface imem_boot_sequencer_if;
    import mips_ctrl_pkg::*;

    logic                   s_valid;
    logic                   s_ready;
    logic [31:0]            s_data;
    logic                   s_last;

    logic                   imem_wen;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [31:0]            imem_wdata;

    logic                   mem_write;
    logic [31:0]            mem_addr;
    logic [31:0]            mem_wdata;

    modport slave (
        input  s_valid, s_data, s_last, mem_write, mem_addr, mem_wdata,
        output s_ready, imem_wen, imem_addr, imem_wdata
    );

    modport master (
        output s_valid, s_data, s_last, mem_write, mem_addr, mem_wdata,
        input  s_ready, imem_wen, imem_addr, imem_wdata
    );

endinterface

// File: rtl/run_watchdog.sv
// Cycle counter for the RUN phase of the boot sequencer.
//   clk       : clock
//   reset_n   : asynchronous active-low reset
//   clr_i     : synchronous clear (takes priority over en_i)
//   en_i      : count this cycle
//   count_o   : cycles counted so far, saturates at TIMEOUT
//   expire_o  : this enabled cycle brings the count to TIMEOUT
module run_watchdog #(
    parameter  int TIMEOUT = 1024,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expire_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_W'(TIMEOUT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flagged one cycle early so the owner can leave RUN on the same edge
    // that makes the count equal TIMEOUT.
    assign expire_o = en_i && (count_q == CNT_W'(TIMEOUT - 1));
    assign count_o  = count_q;

endmodule

// File: rtl/imem_boot_sequencer.sv
// Boot and run controller for the MIPS top.
// Loads a program from a valid/ready word stream into instruction memory,
// holds the CPU in reset for RESET_CYCLES, releases it, then watches the
// data-memory write bus for the pass signature (PASS_ADDR/PASS_DATA) or
// gives up after TIMEOUT run cycles.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : 1-cycle pulse, begins a new load from IDLE/PASS/FAIL
//   bus          : stream in, imem write out, data-memory bus in (slave side)
//   cpu_reset    : active-high CPU reset, registered
//   done/pass    : sticky run finished / signature matched
//   timeout      : sticky, FAIL caused by the watchdog
//   overflow     : sticky, load truncated at MAX_WORDS without s_last
//   word_count   : words written in the current load
//   run_cycles   : cycles spent in RUN
module imem_boot_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter  int          MAX_WORDS    = 256,
    parameter  int          ADDR_STEP    = IMEM_STEP,
    parameter  int          RESET_CYCLES = 2,
    parameter  int          TIMEOUT      = 1024,
    parameter  logic [31:0] PASS_ADDR    = 32'd84,
    parameter  logic [31:0] PASS_DATA    = 32'd7,
    localparam int          WC_W         = $clog2(MAX_WORDS + 1),
    localparam int          RC_W         = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    imem_boot_sequencer_if.slave   bus,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic                   overflow,
    output logic [WC_W-1:0]        word_count,
    output logic [RC_W-1:0]        run_cycles
);

    localparam int RSTC_W = $clog2(RESET_CYCLES + 1);

    boot_state_e            state_q, state_d;
    logic [IMEM_ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [WC_W-1:0]        word_count_q, word_count_d;
    logic [RSTC_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic                   imem_wen_q, imem_wen_d;
    logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]            imem_wdata_q, imem_wdata_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   timeout_q, timeout_d;
    logic                   overflow_q, overflow_d;

    logic                   wd_clr;
    logic                   wd_en;
    logic                   wd_expire;
    logic [WC_W-1:0]        wc_inc;
    logic                   sig_addr_hit;

    run_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_run_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .count_o  (run_cycles),
        .expire_o (wd_expire)
    );

    assign wd_en        = (state_q == RUN);
    assign wc_inc       = word_count_q + 1'b1;
    assign sig_addr_hit = bus.mem_write && (bus.mem_addr == PASS_ADDR);

    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        word_count_d = word_count_q;
        rst_cnt_d    = '0;
        imem_wen_d   = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        overflow_d   = overflow_q;
        wd_clr       = 1'b0;

        case (state_q)
            IDLE, PASS, FAIL: begin
                if (start) begin
                    state_d      = LOAD;
                    addr_cnt_d   = '0;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    overflow_d   = 1'b0;
                    wd_clr       = 1'b1;
                end
            end
            LOAD: begin
                // s_ready is 1 throughout LOAD, so s_valid alone is an accept.
                if (bus.s_valid) begin
                    imem_wen_d   = 1'b1;
                    imem_addr_d  = addr_cnt_q;
                    imem_wdata_d = bus.s_data;
                    addr_cnt_d   = addr_cnt_q + IMEM_ADDR_W'(ADDR_STEP);
                    word_count_d = wc_inc;
                    if (bus.s_last || (wc_inc == WC_W'(MAX_WORDS))) begin
                        state_d = RSTCPU;
                        if (!bus.s_last) begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            RSTCPU: begin
                if (rst_cnt_q == RSTC_W'(RESET_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            RUN: begin
                // Signature has priority over an expiry on the same edge.
                // An X on mem_wdata makes the equality unknown and falls to FAIL.
                if (sig_addr_hit) begin
                    done_d = 1'b1;
                    if (bus.mem_wdata == PASS_DATA) begin
                        state_d = PASS;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = FAIL;
                    end
                end else if (wd_expire) begin
                    state_d   = FAIL;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_reset_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_cnt_q   <= '0;
            word_count_q <= '0;
            rst_cnt_q    <= '0;
            imem_wen_q   <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_cnt_q   <= addr_cnt_d;
            word_count_q <= word_count_d;
            rst_cnt_q    <= rst_cnt_d;
            imem_wen_q   <= imem_wen_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.s_ready    = (state_q == LOAD);
    assign bus.imem_wen   = imem_wen_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign overflow       = overflow_q;
    assign word_count     = word_count_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed bench for imem_boot_sequencer.
// dut_a uses the default parameters; dut_b uses MAX_WORDS=4, TIMEOUT=16.
module tb_imem_boot_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    imem_boot_sequencer_if ia ();
    imem_boot_sequencer_if ib ();

    logic        start_a, cr_a, done_a, pass_a, to_a, ov_a;
    logic [8:0]  wc_a;
    logic [10:0] rc_a;
    logic        start_b, cr_b, done_b, pass_b, to_b, ov_b;
    logic [2:0]  wc_b;
    logic [4:0]  rc_b;

    imem_boot_sequencer dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_a),
        .bus        (ia.slave),
        .cpu_reset  (cr_a),
        .done       (done_a),
        .pass       (pass_a),
        .timeout    (to_a),
        .overflow   (ov_a),
        .word_count (wc_a),
        .run_cycles (rc_a)
    );

    imem_boot_sequencer #(
        .MAX_WORDS (4),
        .TIMEOUT   (16)
    ) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_b),
        .bus        (ib.slave),
        .cpu_reset  (cr_b),
        .done       (done_b),
        .pass       (pass_b),
        .timeout    (to_b),
        .overflow   (ov_b),
        .word_count (wc_b),
        .run_cycles (rc_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start pulse plus an n-word gapless stream; returns in the first RSTCPU cycle.
    task automatic load_a(input int n);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < n; i++) begin
            ia.s_valid = 1'b1;
            ia.s_data  = 32'hA000_0000 + 32'(i);
            ia.s_last  = (i == n - 1);
            tick();
            check("a_wen",   32'(ia.imem_wen), 32'd1);
            check("a_addr",  ia.imem_addr, 32'(4 * i));
            check("a_wdata", ia.imem_wdata, 32'hA000_0000 + 32'(i));
        end
        ia.s_valid = 1'b0;
        ia.s_last  = 1'b0;
    endtask

    task automatic load_b(input int n);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < n; i++) begin
            ib.s_valid = 1'b1;
            ib.s_data  = 32'hB000_0000 + 32'(i);
            ib.s_last  = (i == n - 1);
            tick();
            check("b_addr",  ib.imem_addr, 32'(4 * i));
            check("b_wdata", ib.imem_wdata, 32'hB000_0000 + 32'(i));
        end
        ib.s_valid = 1'b0;
        ib.s_last  = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b1;
        start_a      = 1'b0;
        start_b      = 1'b0;
        ia.s_valid   = 1'b0;
        ia.s_data    = '0;
        ia.s_last    = 1'b0;
        ia.mem_write = 1'b0;
        ia.mem_addr  = '0;
        ia.mem_wdata = '0;
        ib.s_valid   = 1'b0;
        ib.s_data    = '0;
        ib.s_last    = 1'b0;
        ib.mem_write = 1'b0;
        ib.mem_addr  = '0;
        ib.mem_wdata = '0;
        #2 reset_n = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_cpu_reset", 32'(cr_a), 32'd1);
        check("rst_wen",       32'(ia.imem_wen), 32'd0);
        check("rst_addr",      ia.imem_addr, 32'd0);
        check("rst_ready",     32'(ia.s_ready), 32'd0);
        check("rst_done",      32'(done_a), 32'd0);
        check("rst_wc",        32'(wc_a), 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_ready",    32'(ia.s_ready), 32'd0);

        // 1: 14-word load, then two cycles of CPU reset
        load_a(14);
        check("t1_wc",        32'(wc_a), 32'd14);
        check("t1_last_addr", ia.imem_addr, 32'h34);
        check("t1_cr_c1",     32'(cr_a), 32'd1);
        check("t1_ready_off", 32'(ia.s_ready), 32'd0);
        check("t1_ovf",       32'(ov_a), 32'd0);
        tick();
        check("t1_cr_c2",     32'(cr_a), 32'd1);
        check("t1_wen_off",   32'(ia.imem_wen), 32'd0);
        tick();
        check("t1_cr_run",    32'(cr_a), 32'd0);
        check("t1_rc0",       32'(rc_a), 32'd0);

        // 2: signature in RUN cycle 10
        for (int k = 0; k < 9; k++) tick();
        check("t2_not_done", 32'(done_a), 32'd0);
        ia.mem_write = 1'b1;
        ia.mem_addr  = 32'd84;
        ia.mem_wdata = 32'd7;
        tick();
        ia.mem_write = 1'b0;
        check("t2_done", 32'(done_a), 32'd1);
        check("t2_pass", 32'(pass_a), 32'd1);
        check("t2_to",   32'(to_a), 32'd0);
        check("t2_cr",   32'(cr_a), 32'd1);
        check("t2_rc",   32'(rc_a), 32'd10);
        tick();
        check("t2_pass_held", 32'(pass_a), 32'd1);

        // 3: wrong data at the pass address -> FAIL; other address ignored
        load_a(3);
        check("t3_done_clr", 32'(done_a), 32'd0);
        check("t3_pass_clr", 32'(pass_a), 32'd0);
        check("t3_wc",       32'(wc_a), 32'd3);
        tick();
        tick();
        ia.mem_write = 1'b1;
        ia.mem_addr  = 32'd80;
        ia.mem_wdata = 32'd7;
        tick();
        check("t3_addr80_ignored", 32'(done_a), 32'd0);
        ia.mem_addr  = 32'd84;
        ia.mem_wdata = 32'd6;
        tick();
        ia.mem_write = 1'b0;
        check("t3_done", 32'(done_a), 32'd1);
        check("t3_pass", 32'(pass_a), 32'd0);
        check("t3_to",   32'(to_a), 32'd0);

        // 4: timeout after 16 RUN cycles, then signature on cycle 16 wins
        load_b(2);
        tick();
        tick();
        check("t4_cr_run", 32'(cr_b), 32'd0);
        for (int k = 0; k < 15; k++) tick();
        check("t4_rc15",    32'(rc_b), 32'd15);
        check("t4_not_yet", 32'(done_b), 32'd0);
        tick();
        check("t4_done", 32'(done_b), 32'd1);
        check("t4_to",   32'(to_b), 32'd1);
        check("t4_pass", 32'(pass_b), 32'd0);
        check("t4_rc16", 32'(rc_b), 32'd16);
        load_b(2);
        check("t4b_to_clr", 32'(to_b), 32'd0);
        tick();
        tick();
        for (int k = 0; k < 15; k++) tick();
        ib.mem_write = 1'b1;
        ib.mem_addr  = 32'd84;
        ib.mem_wdata = 32'd7;
        tick();
        ib.mem_write = 1'b0;
        check("t4b_pass", 32'(pass_b), 32'd1);
        check("t4b_to",   32'(to_b), 32'd0);
        check("t4b_done", 32'(done_b), 32'd1);

        // 5: MAX_WORDS=4 with a 6-word stream and gaps
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ib.s_valid = 1'b0;
            tick();
            check("t5_gap_wen", 32'(ib.imem_wen), 32'd0);
            ib.s_valid = 1'b1;
            ib.s_data  = 32'hC000_0000 + 32'(i);
            tick();
            check("t5_wen",  32'(ib.imem_wen), 32'd1);
            check("t5_addr", ib.imem_addr, 32'(4 * i));
        end
        check("t5_ready_off", 32'(ib.s_ready), 32'd0);
        check("t5_ovf",       32'(ov_b), 32'd1);
        check("t5_wc",        32'(wc_b), 32'd4);
        ib.s_data = 32'hC000_0004;
        tick();
        check("t5_word5_ignored", 32'(ib.imem_wen), 32'd0);
        ib.s_data = 32'hC000_0005;
        tick();
        ib.s_valid = 1'b0;
        check("t5_run",      32'(cr_b), 32'd0);
        check("t5_ovf_held", 32'(ov_b), 32'd1);
        check("t5_wc_held",  32'(wc_b), 32'd4);

        // 6: async reset mid-LOAD and mid-RUN; start ignored in RUN
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ia.s_valid = 1'b1;
            ia.s_data  = 32'hD000_0000 + 32'(i);
            tick();
        end
        ia.s_valid = 1'b0;
        check("t6_pre_wen", 32'(ia.imem_wen), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_load_cr",    32'(cr_a), 32'd1);
        check("t6_load_wen",   32'(ia.imem_wen), 32'd0);
        check("t6_load_addr",  ia.imem_addr, 32'd0);
        check("t6_load_wdata", ia.imem_wdata, 32'd0);
        check("t6_load_wc",    32'(wc_a), 32'd0);
        check("t6_load_ready", 32'(ia.s_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        load_a(3);
        tick();
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t6_start_ign_cr", 32'(cr_a), 32'd0);
        check("t6_start_ign_wc", 32'(wc_a), 32'd3);
        tick();
        tick();
        check("t6_rc_pre", 32'(rc_a), 32'd3);
        reset_n = 1'b0;
        #1;
        check("t6_run_cr",   32'(cr_a), 32'd1);
        check("t6_run_rc",   32'(rc_a), 32'd0);
        check("t6_run_done", 32'(done_a), 32'd0);
        check("t6_run_wc",   32'(wc_a), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
